data_mem_dp: RTL and testbench

- Parametrised simple-dual-port data memory for the frame buffer; next generation of the single-port-style data memory.
- One write port and one read port operate in the same cycle.
- Adds per-byte write enables, a configurable read pipeline with a valid strobe, and a defined read-during-write policy.
- Adds an optional post-reset clear sequencer that walks the array, so pixel storage starts from a known value without an array-wide reset.

---
 rtl/data_mem_dp.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_dp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_dp.sv
// data_mem_dp: simple-dual-port frame-buffer data memory.
// One write port with per-byte enables and one read port run in the same
// cycle. The read path is a 1..4 stage pipeline with a valid strobe.
// A same-address read and write on one edge returns either the old word
// or the byte-merged new word, depending on RDW_MODE. After reset release,
// an optional sequencer zeroes the array one word per cycle. Reset itself
// leaves the array contents untouched.

module data_mem_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready
);

    localparam int NB = DATA_WIDTH / 8;

    // Addresses are compared one bit wider so that a MEM_DEPTH of exactly
    // 2^ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Replaces each byte of old_word with the matching byte of new_word
    // when its enable bit is set. This is shared by the array write and by
    // the new-data read-during-write bypass, so both always agree.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            res[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return res;
    endfunction

    // Storage array; it has no reset, so it maps onto plain RAM.
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [ADDR_WIDTH-1:0] clr_addr_nxt_s;
    logic                  clr_we_s;
    logic                  ready_r;

    logic                  wr_in_range_s;
    logic                  rd_in_range_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    logic                  last_valid_s;
    logic [DATA_WIDTH-1:0] last_data_s;
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Out-of-range write addresses are dropped. Out-of-range read addresses
    // are still accepted, but they return zero.
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_EXT);

    // Both request strobes are active-low. Requests are only honoured
    // while ready is high.
    assign wr_acc_s = ready_r & ~wr_en & wr_in_range_s;
    assign rd_acc_s = ready_r & ~rd_en;

    // Sequencer next-state logic: INIT -> CLEAR (optional) -> RUN.
    // RUN is left only through reset.
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        clr_we_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                clr_addr_nxt_s = '0;
                if (CLEAR_ON_RESET != 0) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_addr_r == LAST_ADDR) begin
                    state_nxt_s    = ST_RUN;
                    clr_addr_nxt_s = '0;
                end else begin
                    clr_addr_nxt_s = clr_addr_r + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s    = ST_INIT;
                clr_addr_nxt_s = '0;
            end
        endcase
    end

    // Sequencer state, clear pointer and registered ready flag.
    // Asserting reset restarts any clear that is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_INIT;
            clr_addr_r <= '0;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
            ready_r    <= (state_nxt_s == ST_RUN);
        end
    end

    // Array write port: the clear sequencer has priority, otherwise a
    // byte-enabled user write is performed.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_r] <= '0;
        end else if (wr_acc_s) begin
            mem_r[wr_addr] <= merge_bytes(mem_r[wr_addr], wr_data, wr_be);
        end
    end

    // Read word for this edge. In new-data mode, a same-address write on
    // the same edge is bypassed byte by byte into the result.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
            if ((RDW_MODE != 0) && wr_acc_s && (wr_addr == rd_addr)) begin
                rd_word_s = merge_bytes(mem_r[rd_addr], wr_data, wr_be);
            end else begin
                rd_word_s = mem_r[rd_addr];
            end
        end else begin
            rd_word_s = '0;
        end
    end

    // The read pipeline holds RD_LATENCY-1 intermediate stages, followed by
    // the output register. With latency 1, the output register samples the
    // array directly.
    generate
        if (RD_LATENCY <= 1) begin : g_lat1
            assign last_valid_s = rd_acc_s;
            assign last_data_s  = rd_word_s;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] pv_r;
            logic [DATA_WIDTH-1:0] pd_r [RD_LATENCY-1];

            // Intermediate read stages. Reset empties them so that reads
            // in flight are discarded.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pv_r <= '0;
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pd_r[i] <= '0;
                    end
                end else begin
                    pv_r[0] <= rd_acc_s;
                    pd_r[0] <= rd_word_s;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pd_r[i] <= pd_r[i-1];
                    end
                end
            end

            assign last_valid_s = pv_r[RD_LATENCY-2];
            assign last_data_s  = pd_r[RD_LATENCY-2];
        end
    endgenerate

    // Output register. rd_data only changes when a result is delivered, so
    // it holds its last value between results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= last_valid_s;
            if (last_valid_s) begin
                rd_data_r <= last_data_s;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign ready    = ready_r;

endmodule

// File: tb/tb_data_mem_dp.sv
// tb_data_mem_dp: scoreboard bench for data_mem_dp.
// Three instances share the same stimulus:
//   instance i uses RD_LATENCY = i+1 and RDW_MODE = i%2.
// All instances use MEM_DEPTH = 12 and ADDR_WIDTH = 4.
// The stimulus pushes the expected word and its due cycle per instance.
// A negedge monitor pops each entry and compares it against rd_valid/rd_data.

module tb_data_mem_dp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 12;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_s [NI];
    logic [NI-1:0] rd_valid_s;
    logic [NI-1:0] ready_s;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            data_mem_dp #(
                .DATA_WIDTH    (DW),
                .ADDR_WIDTH    (AW),
                .MEM_DEPTH     (DEPTH),
                .RD_LATENCY    (g + 1),
                .RDW_MODE      (g % 2),
                .CLEAR_ON_RESET(1)
            ) u_dut (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_en),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .wr_be   (wr_be),
                .rd_en   (rd_en),
                .rd_addr (rd_addr),
                .rd_data (rd_data_s[g]),
                .rd_valid(rd_valid_s[g]),
                .ready   (ready_s[g])
            );
        end
    endgenerate

    task automatic push(input int idx, input logic [31:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest expectation,
    // with the right data on the right cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < NI; i++) begin
            have = 1'b0;
            case (i)
                0:       if (q0.size() > 0) begin e = q0[0]; have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1[0]; have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2[0]; have = 1'b1; end
            endcase
            if (rd_valid_s[i] === 1'b1) begin
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL rd_unexpected inst %0d cycle %0d: got rd_valid data %h, required no rd_valid",
                             i, cyc, rd_data_s[i]);
                end else begin
                    case (i)
                        0:       void'(q0.pop_front());
                        1:       void'(q1.pop_front());
                        default: void'(q2.pop_front());
                    endcase
                    if (rd_data_s[i] !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL rd_data inst %0d: got %h at cycle %0d, required %h at cycle %0d",
                                 i, rd_data_s[i], cyc, e.data, e.due);
                    end
                end
            end else if (have && e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing inst %0d cycle %0d: got no rd_valid, required %h at cycle %0d",
                         i, cyc, e.data, e.due);
                case (i)
                    0:       void'(q0.pop_front());
                    1:       void'(q1.pop_front());
                    default: void'(q2.pop_front());
                endcase
            end
        end
    end

    task automatic idle();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_be = 4'h0;
    endtask

    // One request cycle. e0 is the expected read word for RDW_MODE=0 and
    // e1 the word for RDW_MODE=1. mask selects which instances expect a result.
    task automatic txn(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                       input bit re, input int ra, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [2:0] mask);
        @(negedge clk);
        wr_en   = ~we;
        wr_addr = AW'(wa);
        wr_data = wd;
        wr_be   = be;
        rd_en   = ~re;
        rd_addr = AW'(ra);
        if (re) begin
            for (int i = 0; i < NI; i++) begin
                if (mask[i]) push(i, (i % 2 == 1) ? e1 : e0, cyc + i + 1);
            end
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        txn(1'b1, a, d, be, 1'b0, 0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        txn(1'b0, 0, 32'h0, 4'h0, 1'b1, a, e, e, 3'b111);
    endtask

    task automatic nop();
        @(negedge clk);
        idle();
    endtask

    // After release: ready must be low for INIT plus 12 clear edges and
    // high after edge 13. Requests driven during this window must be ignored.
    task automatic wait_ready(input string tag);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk(tag, 32'(ready_s), (k == 13) ? 32'h7 : 32'h0);
            if (k < 13) begin
                wr_en   = 1'b0;
                wr_addr = 4'd0;
                wr_data = 32'hFFFF_FFFF;
                wr_be   = 4'hF;
                rd_en   = 1'b0;
                rd_addr = 4'd0;
            end else begin
                idle();
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 32'h0;
        rd_addr = 4'd0;
        idle();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_s), 32'h0);
        chk("rst_valid", 32'(rd_valid_s), 32'h0);
        for (int i = 0; i < NI; i++) chk("rst_data", rd_data_s[i], 32'h0);

        reset = 1'b1;
        wait_ready("ready_after_clear");
        for (int a = 0; a < DEPTH; a++) rd(a, 32'h0);

        // Byte-enable writes, then a no-op write with all byte enables clear.
        wr(3, 32'hAABB_CCDD, 4'hF);
        wr(3, 32'h1122_3344, 4'h5);
        rd(3, 32'hAA22_CC44);
        wr(9, 32'hFFFF_FFFF, 4'h0);
        rd(9, 32'h0);

        // Read-during-write at the same address: full-word and partial.
        txn(1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b1, 5, 32'h0, 32'hDEAD_BEEF, 3'b111);
        rd(5, 32'hDEAD_BEEF);
        txn(1'b1, 3, 32'h5566_7788, 4'h3, 1'b1, 3, 32'hAA22_CC44, 32'hAA22_7788, 3'b111);
        rd(3, 32'hAA22_7788);

        // Read-during-write at different addresses: no interaction.
        txn(1'b1, 4, 32'h1234_5678, 4'hF, 1'b1, 6, 32'h0, 32'h0, 3'b111);
        rd(4, 32'h1234_5678);

        // Streaming reads, one per cycle.
        for (int a = 0; a < 8; a++) wr(a, 32'(a * 16), 4'hF);
        for (int a = 0; a < 8; a++) rd(a, 32'(a * 16));

        // Out-of-range writes are dropped; out-of-range reads return zero.
        wr(13, 32'h5, 4'hF);
        wr(12, 32'h5, 4'hF);
        rd(13, 32'h0);
        rd(12, 32'h0);
        for (int a = 0; a < DEPTH; a++) rd(a, (a < 8) ? 32'(a * 16) : 32'h0);

        // rd_data holds its last value while rd_valid is low.
        rd(7, 32'h70);
        nop();
        repeat (4) @(negedge clk);
        chk("hold_valid", 32'(rd_valid_s), 32'h0);
        for (int i = 0; i < NI; i++) chk("hold_data", rd_data_s[i], 32'h70);

        // Reset with reads in flight. Only the latency-1 result of the first
        // read completes before reset; everything later is discarded.
        txn(1'b0, 0, 32'h0, 4'h0, 1'b1, 1, 32'h10, 32'h10, 3'b001);
        txn(1'b0, 0, 32'h0, 4'h0, 1'b1, 2, 32'h20, 32'h20, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        #1;
        chk("midrst_valid", 32'(rd_valid_s), 32'h0);
        chk("midrst_ready", 32'(ready_s), 32'h0);
        for (int i = 0; i < NI; i++) chk("midrst_data", rd_data_s[i], 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset again during the clear, once clr_addr has reached 6 (after edge 7).
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ready("ready_restart");
        for (int a = 0; a < DEPTH; a++) rd(a, 32'h0);
        nop();

        repeat (8) @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'h0);
        chk("q1_empty", 32'(q1.size()), 32'h0);
        chk("q2_empty", 32'(q2.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
